booth_div: RTL and testbench

//   Iterative signed integer divider: the inverse of the ALU's combinational

---
 rtl/booth_div.sv | 169 ++++++++++++++++
 tb/tb_booth_div.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_div.sv
// booth_div: iterative divider producing one quotient bit per clock by
// non-restoring division on operand magnitudes, with signs applied at the end.
// Invariant: A == Quotient*B + Remainder, truncating toward zero.
//
// Parameters:
//   WIDTH       operand/result width in bits (>= 4)
//   SIGNED      1 = two's-complement operands, 0 = unsigned operands
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       request, sampled only in IDLE
//   A, B        dividend / divisor, captured on an accepted start
//   busy        high while an operation is in flight (RUN/FIX/SPEC)
//   done        one-cycle pulse, results valid
//   Quotient    quotient, held until the next result
//   Remainder   remainder with the sign of the dividend, held likewise
//   div_by_zero set with done when B==0, cleared on an accepted start
module booth_div #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FIX,
    SPEC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_raw;      // original dividend, needed for B==0 result
  logic [WIDTH-1:0] b_mag;      // |B|
  logic [WIDTH-1:0] q_sh;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH:0]   prem;       // signed partial remainder
  logic             neg_q;
  logic             neg_r;
  logic             spec_zero;  // SPEC was entered because B==0

  // Operand classification on the live inputs (used only when accepting start)
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             b_zero, ovf;

  always_comb begin
    a_neg  = SIGNED && A[WIDTH-1];
    b_neg  = SIGNED && B[WIDTH-1];
    // |MIN| is representable once the result is read as unsigned
    a_abs  = a_neg ? -A : A;
    b_abs  = b_neg ? -B : B;
    b_zero = (B == '0);
    ovf    = SIGNED && (A == MIN_VAL) && (B == '1);
  end

  // One non-restoring step: the operation is chosen from the sign of the
  // current partial remainder; the new sign gives the next quotient bit.
  logic [WIDTH:0] p_sh, p_step, b_ext;

  always_comb begin
    b_ext  = {1'b0, b_mag};
    p_sh   = {prem[WIDTH-1:0], q_sh[WIDTH-1]};
    p_step = prem[WIDTH] ? (p_sh + b_ext) : (p_sh - b_ext);
  end

  // Final correction and sign application. The corrected remainder lies in
  // [0, |B|), so WIDTH-bit arithmetic is sufficient.
  logic [WIDTH-1:0] r_mag, q_final, r_final;

  always_comb begin
    r_mag   = prem[WIDTH] ? (prem[WIDTH-1:0] + b_mag) : prem[WIDTH-1:0];
    q_final = neg_q ? -q_sh : q_sh;
    r_final = neg_r ? -r_mag : r_mag;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (b_zero || ovf) ? SPEC : RUN;
      RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      SPEC: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == RUN) || (state == FIX) || (state == SPEC);
    done = (state == DONE);
  end

  // Datapath; results are written only on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      a_raw       <= '0;
      b_mag       <= '0;
      q_sh        <= '0;
      prem        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      spec_zero   <= 1'b0;
      Quotient    <= '0;
      Remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_raw       <= A;
            b_mag       <= b_abs;
            q_sh        <= a_abs;
            prem        <= '0;
            cnt         <= '0;
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            spec_zero   <= b_zero;
            div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          prem <= p_step;
          q_sh <= {q_sh[WIDTH-2:0], ~p_step[WIDTH]};
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          Quotient  <= q_final;
          Remainder <= r_final;
        end
        SPEC: begin
          if (spec_zero) begin
            Quotient    <= '1;
            Remainder   <= a_raw;
            div_by_zero <= 1'b1;
          end else begin
            Quotient  <= MIN_VAL;
            Remainder <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_div.sv
module tb_booth_div;

  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        s_start = 1'b0, u_start = 1'b0;
  logic [31:0] s_a = '0, s_b = '0, u_a = '0, u_b = '0;
  logic        s_busy, s_done, s_dbz, u_busy, u_done, u_dbz;
  logic [31:0] s_q, s_r, u_q, u_r;

  booth_div #(.WIDTH(32), .SIGNED(1'b1)) u_sig (
    .clk(clk), .rst(rst), .start(s_start), .A(s_a), .B(s_b),
    .busy(s_busy), .done(s_done), .Quotient(s_q), .Remainder(s_r),
    .div_by_zero(s_dbz)
  );

  booth_div #(.WIDTH(32), .SIGNED(1'b0)) u_uns (
    .clk(clk), .rst(rst), .start(u_start), .A(u_a), .B(u_b),
    .busy(u_busy), .done(u_done), .Quotient(u_q), .Remainder(u_r),
    .div_by_zero(u_dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t qs[$];
  exp_t qu[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer division in 64-bit arithmetic
  function automatic exp_t ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint na, nb, qq, rr;
    if (b == 32'd0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else begin
      if (sgn) begin
        na = $signed(a); nb = $signed(b);
      end else begin
        na = {32'd0, a}; nb = {32'd0, b};
      end
      qq = na / nb;
      rr = na % nb;
      e.q = qq[31:0]; e.r = rr[31:0]; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && s_done) begin
      if (qs.size() == 0) begin
        checks++; errors++;
        $display("FAIL sig_unexpected_done got done=1 expected no pending result");
      end else begin
        e = qs.pop_front();
        chk("sig_quotient", s_q, e.q);
        chk("sig_remainder", s_r, e.r);
        chk("sig_div_by_zero", {31'd0, s_dbz}, {31'd0, e.dbz});
      end
    end
    if (!rst && u_done) begin
      if (qu.size() == 0) begin
        checks++; errors++;
        $display("FAIL uns_unexpected_done got done=1 expected no pending result");
      end else begin
        e = qu.pop_front();
        chk("uns_quotient", u_q, e.q);
        chk("uns_remainder", u_r, e.r);
        chk("uns_div_by_zero", {31'd0, u_dbz}, {31'd0, e.dbz});
      end
    end
  end

  // Wait for IDLE, present one request, return just after the accepting edge
  task automatic issue(input bit uns, input logic [31:0] a, input logic [31:0] b, input bit push);
    int unsigned k = 0;
    @(negedge clk);
    while (((uns ? u_busy : s_busy) || (uns ? u_done : s_done)) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      checks++; errors++;
      $display("FAIL issue_timeout got busy after %0d cycles expected idle", k);
    end else begin
      if (uns) begin u_start = 1'b1; u_a = a; u_b = b; end
      else     begin s_start = 1'b1; s_a = a; s_b = b; end
      if (push) begin
        if (uns) qu.push_back(ref_div(1'b0, a, b));
        else     qs.push_back(ref_div(1'b1, a, b));
      end
      @(posedge clk);
      #1;
      if (uns) u_start = 1'b0;
      else     s_start = 1'b0;
    end
  endtask

  // Signed operation with latency measurement; returns in the done cycle
  task automatic timed(input logic [31:0] a, input logic [31:0] b, input int lat, input string name);
    int n;
    issue(1'b0, a, b, 1'b1);
    n = 1;
    @(negedge clk);
    chk({name, "_busy"}, {31'd0, s_busy}, 32'd1);
    while (!s_done && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({name, "_latency"}, n, lat);
    chk({name, "_busy_in_done"}, {31'd0, s_busy}, 32'd0);
  endtask

  task automatic gen(output logic [31:0] a, output logic [31:0] b);
    int unsigned sel;
    sel = $urandom_range(0, 9);
    a = $urandom;
    b = $urandom;
    case (sel)
      0: b = '0;
      1: begin a = MIN32; b = '1; end
      2: begin
           b = $urandom_range(1, 15);
           if ($urandom_range(0, 1) == 1) b = -b;
         end
      3: a = $urandom_range(0, 20);
      4: b = b >> $urandom_range(0, 31);
      default: ;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, s_busy}, 32'd0);
    chk("reset_done", {31'd0, s_done}, 32'd0);
    chk("reset_quotient", s_q, 32'd0);
    chk("reset_remainder", s_r, 32'd0);
    chk("reset_dbz", {31'd0, s_dbz}, 32'd0);
    chk("reset_uns_quotient", u_q, 32'd0);
    rst = 1'b0;

    // Unsigned directed cases
    issue(1'b1, 32'hFFFF_FFF0, 32'd7, 1'b1);
    issue(1'b1, 32'h1234_5678, 32'd0, 1'b1);
    issue(1'b1, MIN32, 32'hFFFF_FFFF, 1'b1);

    // Signed directed cases with latency
    timed(32'd100, 32'd7, 34, "pos_pos");
    // start during the DONE cycle must be ignored
    s_start = 1'b1; s_a = 32'd55; s_b = 32'd5;
    @(posedge clk);
    #1 s_start = 1'b0;
    @(negedge clk);
    chk("start_in_done_ignored", {31'd0, s_busy}, 32'd0);

    timed(32'hFFFF_FF9C, 32'd7, 34, "neg_pos");
    timed(32'd100, 32'hFFFF_FFF9, 34, "pos_neg");
    timed(32'd5, 32'd0, 2, "div_zero");
    timed(MIN32, 32'hFFFF_FFFF, 2, "overflow");

    // Re-pulsed start while busy
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    s_start = 1'b1; s_a = 32'd999; s_b = 32'd3;
    @(posedge clk);
    #1 s_start = 1'b0;

    // Drain before the reset test
    dn = 0;
    while ((qs.size() != 0 || qu.size() != 0 || s_busy || u_busy) && dn < 500) begin
      @(negedge clk);
      dn++;
    end
    chk("drain_before_reset", {31'd0, (dn < 500)}, 32'd1);

    // Reset mid-operation
    issue(1'b0, 32'd1234, 32'd5, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_busy", {31'd0, s_busy}, 32'd0);
    chk("midreset_done", {31'd0, s_done}, 32'd0);
    chk("midreset_quotient", s_q, 32'd0);
    chk("midreset_remainder", s_r, 32'd0);
    chk("midreset_dbz", {31'd0, s_dbz}, 32'd0);
    dn = 0;
    repeat (50) begin
      @(negedge clk);
      if (s_done) dn++;
    end
    chk("midreset_no_done", dn, 0);

    // Randomized back-to-back operation on both variants
    fork
      begin
        logic [31:0] xa, xb;
        for (int i = 0; i < 1200; i++) begin
          gen(xa, xb);
          issue(1'b0, xa, xb, 1'b1);
        end
      end
      begin
        logic [31:0] ya, yb;
        for (int j = 0; j < 1200; j++) begin
          gen(ya, yb);
          issue(1'b1, ya, yb, 1'b1);
        end
      end
    join

    dn = 0;
    while ((qs.size() != 0 || qu.size() != 0) && dn < 200) begin
      @(negedge clk);
      dn++;
    end
    chk("sig_queue_empty", qs.size(), 0);
    chk("uns_queue_empty", qu.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
